// File: rtl/ascon_aead128_pkg.sv
// Shared Ascon types, round-constant table and permutation start indices.
// Used by ascon_round and ascon_perm_seq.
package ascon_aead128_pkg;

  typedef struct packed {
    logic [63:0] s0;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] s3;
    logic [63:0] s4;
  } ascon_state;

  typedef logic [3:0] round_t;

  typedef enum logic {
    StIdle,
    StRun
  } perm_fsm_e;

  // Indexed by round number; p^a uses 4..F and p^b uses 8..F.
  localparam logic [7:0] CONST_ADD [16] = '{
    8'h3c, 8'h2d, 8'h1e, 8'h0f, 8'hf0, 8'he1, 8'hd2, 8'hc3,
    8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  localparam round_t RND_START_PA = 4'h4;
  localparam round_t RND_START_PB = 4'h8;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition into s2, bitsliced 5-bit
// S-box layer, then the per-word linear diffusion layer.
module ascon_round
  import ascon_aead128_pkg::*;
(
  input  round_t     rnd_i,
  input  ascon_state state_i,
  output ascon_state state_o
);

  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] c0, c1, c2, c3, c4;

  always_comb begin
    a0 = state_i.s0 ^ state_i.s4;
    a1 = state_i.s1;
    a2 = state_i.s2 ^ {56'h0, CONST_ADD[rnd_i]} ^ state_i.s1;
    a3 = state_i.s3;
    a4 = state_i.s4 ^ state_i.s3;

    // Chi-like nonlinear step.
    b0 = a0 ^ (~a1 & a2);
    b1 = a1 ^ (~a2 & a3);
    b2 = a2 ^ (~a3 & a4);
    b3 = a3 ^ (~a4 & a0);
    b4 = a4 ^ (~a0 & a1);

    c0 = b0 ^ b4;
    c1 = b1 ^ b0;
    c2 = ~b2;
    c3 = b3 ^ b2;
    c4 = b4;

    state_o.s0 = c0 ^ ror64(c0, 19) ^ ror64(c0, 28);
    state_o.s1 = c1 ^ ror64(c1, 61) ^ ror64(c1, 39);
    state_o.s2 = c2 ^ ror64(c2, 1) ^ ror64(c2, 6);
    state_o.s3 = c3 ^ ror64(c3, 10) ^ ror64(c3, 17);
    state_o.s4 = c4 ^ ror64(c4, 7) ^ ror64(c4, 41);
  end

endmodule

// File: rtl/ascon_perm_seq.sv
// Sequential Ascon-p engine: RND_PER_CYC chained rounds per clock, 12 or 8 rounds.
// Optional abort input enabled by defining ASCON_PERM_ABORT_EN.
module ascon_perm_seq
  import ascon_aead128_pkg::*;
#(
  parameter int unsigned RND_PER_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       nr12_i,
  input  ascon_state state_i,
`ifdef ASCON_PERM_ABORT_EN
  input  logic       abort_i,
`endif
  output logic       ready_o,
  output logic       done_o,
  output round_t     rnd_o,
  output ascon_state state_o
);

  if (!(RND_PER_CYC == 1 || RND_PER_CYC == 2 || RND_PER_CYC == 4)) begin : gen_bad_param
    $error("ascon_perm_seq: RND_PER_CYC must be 1, 2 or 4");
  end

  localparam round_t RND_STEP = round_t'(RND_PER_CYC);
  localparam round_t RND_LAST = round_t'(16 - RND_PER_CYC);

  perm_fsm_e  fsm_q, fsm_d;
  round_t     rnd_q, rnd_d;
  ascon_state st_q, st_d;
  logic       done_q, done_d;

  ascon_state chain [RND_PER_CYC + 1];

  assign chain[0] = st_q;

  for (genvar i = 0; i < RND_PER_CYC; i++) begin : gen_round
    round_t rnd_k;
    assign rnd_k = rnd_q + round_t'(i);

    ascon_round u_round (
      .rnd_i   (rnd_k),
      .state_i (chain[i]),
      .state_o (chain[i+1])
    );
  end

  always_comb begin
    fsm_d  = fsm_q;
    rnd_d  = rnd_q;
    st_d   = st_q;
    done_d = 1'b0;
    unique case (fsm_q)
      StIdle: begin
        if (start_i) begin
          st_d  = state_i;
          rnd_d = nr12_i ? RND_START_PA : RND_START_PB;
          fsm_d = StRun;
        end
      end
      StRun: begin
        st_d  = chain[RND_PER_CYC];
        // Wraps to 0 on the final step, leaving rnd_o at 0 while idle.
        rnd_d = rnd_q + RND_STEP;
        if (rnd_q == RND_LAST) begin
          fsm_d  = StIdle;
          done_d = 1'b1;
        end
`ifdef ASCON_PERM_ABORT_EN
        if (abort_i) begin
          fsm_d  = StIdle;
          st_d   = '0;
          rnd_d  = '0;
          done_d = 1'b0;
        end
`endif
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q  <= StIdle;
      rnd_q  <= '0;
      st_q   <= '0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      rnd_q  <= rnd_d;
      st_q   <= st_d;
      done_q <= done_d;
    end
  end

  assign ready_o = (fsm_q == StIdle);
  assign done_o  = done_q;
  assign rnd_o   = rnd_q;
  assign state_o = st_q;

endmodule

// File: tb/tb_ascon_perm_seq.sv
// Bench for ascon_perm_seq: three instances (1, 2, 4 rounds per cycle) scored
// cycle by cycle against a table-driven Ascon-p model.
module tb_ascon_perm_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         nr12;
  logic [319:0] st_in;
  logic         abort;

  logic         rdy [3];
  logic         dn  [3];
  logic [3:0]   rn  [3];
  logic [319:0] so  [3];

  int checks = 0;
  int failures = 0;

  int           rpc_tab [3] = '{1, 2, 4};
  int           rem     [3];
  logic [3:0]   m_rnd   [3];
  logic [319:0] m_st    [3];
  logic         m_done  [3];

  always #5 clk = ~clk;

  ascon_perm_seq #(.RND_PER_CYC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .nr12_i(nr12), .state_i(st_in),
`ifdef ASCON_PERM_ABORT_EN
    .abort_i(abort),
`endif
    .ready_o(rdy[0]), .done_o(dn[0]), .rnd_o(rn[0]), .state_o(so[0])
  );

  ascon_perm_seq #(.RND_PER_CYC(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .nr12_i(nr12), .state_i(st_in),
`ifdef ASCON_PERM_ABORT_EN
    .abort_i(abort),
`endif
    .ready_o(rdy[1]), .done_o(dn[1]), .rnd_o(rn[1]), .state_o(so[1])
  );

  ascon_perm_seq #(.RND_PER_CYC(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .nr12_i(nr12), .state_i(st_in),
`ifdef ASCON_PERM_ABORT_EN
    .abort_i(abort),
`endif
    .ready_o(rdy[2]), .done_o(dn[2]), .rnd_o(rn[2]), .state_o(so[2])
  );

  // Reference rounds using the 5-bit S-box lookup table, column by column.
  function automatic logic [319:0] tb_rounds(input logic [319:0] st, input int first,
                                             input int n);
    logic [63:0] x [5];
    logic [4:0]  sb [32];
    int          ra [5];
    int          rb [5];
    logic [4:0]  col;
    logic [4:0]  o;
    logic [7:0]  c;
    logic [63:0] v;
    sb = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
           5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
           5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
           5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    ra = '{19, 61, 1, 10, 7};
    rb = '{28, 39, 6, 17, 41};
    for (int i = 0; i < 5; i++) x[i] = st[319-64*i -: 64];
    for (int r = first; r < first + n; r++) begin
      c = {4'((3 - r) & 15), 4'((r + 12) & 15)};
      x[2] = x[2] ^ {56'h0, c};
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o = sb[col];
        x[0][b] = o[4];
        x[1][b] = o[3];
        x[2][b] = o[2];
        x[3][b] = o[1];
        x[4][b] = o[0];
      end
      for (int i = 0; i < 5; i++) begin
        v = x[i];
        x[i] = v ^ ((v >> ra[i]) | (v << (64 - ra[i]))) ^ ((v >> rb[i]) | (v << (64 - rb[i])));
      end
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Advance one clock, update the model with the inputs seen at that edge, compare.
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        rem[k] = 0; m_rnd[k] = 4'h0; m_st[k] = '0; m_done[k] = 1'b0;
      end else if (rem[k] == 0) begin
        m_done[k] = 1'b0;
        if (start) begin
          rem[k]   = (nr12 ? 12 : 8) / rpc_tab[k];
          m_rnd[k] = nr12 ? 4'h4 : 4'h8;
          m_st[k]  = st_in;
        end
      end else if (abort) begin
        rem[k] = 0; m_rnd[k] = 4'h0; m_st[k] = '0; m_done[k] = 1'b0;
      end else begin
        m_st[k]   = tb_rounds(m_st[k], int'(m_rnd[k]), rpc_tab[k]);
        m_rnd[k]  = m_rnd[k] + 4'(rpc_tab[k]);
        rem[k]    = rem[k] - 1;
        m_done[k] = (rem[k] == 0);
      end
      checks++;
      if ({rdy[k], dn[k], rn[k]} !== {rem[k] == 0, m_done[k], m_rnd[k]}) begin
        failures++;
        $display("FAIL ctl rpc=%0d t=%0t: got ready=%b done=%b rnd=%h, want ready=%b done=%b rnd=%h",
                 rpc_tab[k], $time, rdy[k], dn[k], rn[k], rem[k] == 0, m_done[k], m_rnd[k]);
      end
      checks++;
      if (so[k] !== m_st[k]) begin
        failures++;
        $display("FAIL state rpc=%0d t=%0t: got %h want %h", rpc_tab[k], $time, so[k], m_st[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    st_in = rand320();
    step();
    step();
    rst_n = 1'b1;
    start = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_pa_init();
    nr12  = 1'b1;
    st_in = {64'h00001000808c0001, 256'h0};
    start = 1'b1;
    step();
    start = 1'b0;
    st_in = rand320();
    repeat (14) step();
  endtask

  task automatic test_pb_zero();
    nr12  = 1'b0;
    st_in = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_busy_ignore();
    repeat (60) begin
      start = 1'($urandom_range(0, 1));
      nr12  = 1'($urandom_range(0, 1));
      st_in = rand320();
      step();
    end
    start = 1'b0;
    repeat (14) step();
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    repeat (40) begin
      nr12  = 1'($urandom_range(0, 1));
      st_in = rand320();
      step();
    end
    start = 1'b0;
    repeat (14) step();
  endtask

  task automatic test_reset_mid();
    nr12  = 1'b1;
    st_in = rand320();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    st_in = rand320();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (13) step();
  endtask

`ifdef ASCON_PERM_ABORT_EN
  task automatic test_abort();
    nr12  = 1'b1;
    st_in = rand320();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (11) step();
    abort = 1'b1;
    start = 1'b1;
    st_in = rand320();
    step();
    abort = 1'b0;
    start = 1'b0;
    repeat (13) step();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    nr12  = 1'b0;
    st_in = '0;
    abort = 1'b0;
    test_reset();
    test_pa_init();
    test_pb_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef ASCON_PERM_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ascon_perm_seq.md
Name: ascon_perm_seq

Overview:
Sequential Ascon-p permutation engine. It is the driver side of the round-constant interface: it generates the round index sequence and feeds the round function (constant addition, substitution layer, linear layer) once or several times per clock. A load/start handshake brings in a 320-bit state. The engine iterates 12 rounds (p^a) or 8 rounds (p^b) and returns the permuted state with a done pulse. The AEAD128 mode controller instantiates it for initialization, data absorption and finalization.

Parameters:
RND_PER_CYC, 1, rounds evaluated combinationally per clock; legal values 1, 2, 4 (must divide 8 and 12); any other value raises an elaboration error.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start_i  input  1  request a permutation; accepted only while ready_o=1
nr12_i  input  1  sampled with start_i; 1 = 12 rounds (p^a), 0 = 8 rounds (p^b)
state_i  input  320  ascon_state to permute; sampled with start_i
ready_o  output  1  engine idle, can accept start_i
done_o  output  1  one-cycle pulse when state_o holds the result
rnd_o  output  4  round index applied first in the current cycle (type round)
state_o  output  320  registered working state / result (ascon_state)

Behaviour:
- Reset (rst_n=0 at a clock edge, any state, including mid-permutation):
  - FSM goes to IDLE; state_o=0, rnd_o=4'h0, ready_o=1, done_o=0.
  - Any in-flight permutation is discarded with no done_o.
- FSM has two states, IDLE and RUN.
- IDLE:
  - ready_o=1.
  - On start_i=1: state register <= state_i; rnd <= 4'h4 if nr12_i else 4'h8; go to RUN; ready_o drops next cycle.
  - start_i=0: state_o and rnd_o hold.
- RUN, each cycle:
  - Apply RND_PER_CYC chained rounds using indices rnd, rnd+1, ..., rnd+RND_PER_CYC-1.
  - Round k uses constant const_add[k] XORed into s2, then the S-box layer, then the linear layer.
  - state register <= result; rnd <= rnd+RND_PER_CYC.
- Last cycle: rnd == 16-RND_PER_CYC (the final round index is 4'hF).
  - On that edge: go to IDLE; done_o=1 for exactly the following cycle; ready_o=1 in that same cycle.
  - 4-bit rnd wraps to 4'h0 on that edge; rnd_o shows 4'h0 in IDLE after completion.
- Latency from start acceptance to done_o, in cycles: p^a = 12/RND_PER_CYC; p^b = 8/RND_PER_CYC.
- Back-to-back: start_i in the done_o cycle is accepted. Its result overwrites state_o on the next edge, so the consumer must capture state_o in the done_o cycle.
- start_i while RUN: ignored; state_i and nr12_i are not sampled.
- state_o is valid only in the done_o cycle and while in IDLE afterwards. During RUN it shows intermediate states.
- Round index never leaves 4..F during RUN; the round function must not be evaluated with an index below 4.

Optional Feature:
ASCON_PERM_ABORT_EN
- Defined:
  - Adds input port abort_i (1 bit).
  - abort_i=1 during RUN: next edge goes to IDLE with no done_o; state_o is cleared to 0; rnd_o=4'h0.
  - abort_i has priority over round completion in the same cycle.
  - abort_i in IDLE has no effect; a simultaneous start_i is still accepted.
- Not defined: port absent; permutations always run to completion.

Decomposition:
- Shared package ascon_aead128_pkg holds:
  - types ascon_state (s0..s4, 64 bits each) and round (4-bit);
  - const_add table;
  - new constants RND_START_PA=4'h4 and RND_START_PB=4'h8.
- Sub-module ascon_round (one full round: constant addition, substitution, linear layer; inputs rnd and state) is instantiated RND_PER_CYC times in a generate chain.
- The FSM and counter live in ascon_perm_seq.

Test Plan:
- Reset then idle: rst_n low 2 cycles -> ready_o=1, done_o=0, state_o=0, rnd_o=0; holds with start_i=0.
- p^a, RND_PER_CYC=1: state_i = AEAD128 init state (IV 0x00001000808c0001, key=0, nonce=0), nr12_i=1 -> rnd_o steps 4,5,...,F; done_o exactly 12 cycles after acceptance; state_o matches golden model Ascon-p[12].
- p^b, RND_PER_CYC=2 and 4: state_i=0, nr12_i=0 -> done_o after 4 and 2 cycles; rnd_o steps 8,A,C,E and 8,C; result matches golden Ascon-p[8](0).
- Back-to-back and busy: start_i held high continuously -> one permutation per 12/RND_PER_CYC+0 gaps; start_i pulses during RUN are ignored (state_i changes have no effect on results).
- Reset mid-run: rst_n low at round 7 -> next cycle IDLE, state_o=0, no done_o; a fresh start then completes correctly.
- ASCON_PERM_ABORT_EN: abort_i in the last RUN cycle -> no done_o, state_o=0, ready_o=1 next cycle.
